cmd_frame_rcvr: RTL

Responder-side UART endpoint for the command channel. It receives the 3-byte command frame sent by CommMaster (cmd, data[15:8], data[7:0]) on RX and presents cmd/data with a cmd_rdy/clr_cmd_rdy handshake. It also serializes a 1-byte response on TX when snd_resp is pulsed. It is self-contained: it has its own bit-level RX/TX shifters and baud counters and does not instantiate other UART blocks.

---
 rtl/cmd_frame_rcvr.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cmd_frame_rcvr.sv
// Purpose : command-channel UART responder; assembles 3-byte frames (cmd, data hi, data lo) from RX
//           and serializes a 1-byte response on TX. Optional macro STOP_BIT_CHK_EN enables stop-bit checking.
// Latency : cmd/data/cmd_rdy update 2 clocks after the last byte's stop-bit sample; TX starts 1 clock after snd_resp.
// Backpressure: none on RX (an unconsumed frame is overwritten); snd_resp while tx_busy is dropped.
// Ports   : clk/rst_n (sync, active-low); RX/TX serial lines (idle high); cmd, data, cmd_rdy, clr_cmd_rdy
//           frame handshake; snd_resp, resp, resp_sent, tx_busy response path; frm_err framing-error pulse.
module cmd_frame_rcvr #(
   parameter int BAUD_DIV = 2604
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic        TX,
   output logic [7:0]  cmd,
   output logic [15:0] data,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic        snd_resp,
   input  logic [7:0]  resp,
   output logic        resp_sent,
   output logic        tx_busy,
   output logic        frm_err
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

   // ---------------- RX bit engine ----------------
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

   rx_state_e      rx_state_q, rx_state_d;
   logic           rx_meta_q, rx_sync_q, rx_prev_q;
   logic [CW-1:0]  rx_cnt_q, rx_cnt_d;
   logic [2:0]     rx_bit_q, rx_bit_d;
   logic [7:0]     rx_shift_q, rx_shift_d;
   logic           byte_done;
   logic           start_ok;
`ifdef STOP_BIT_CHK_EN
   logic           stop_bad;
`endif

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + 1'b1;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      byte_done  = 1'b0;
      start_ok   = 1'b0;
`ifdef STOP_BIT_CHK_EN
      stop_bad   = 1'b0;
`endif
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
         end
         RX_START: begin
            // Resample mid start bit; a high level here was only a glitch.
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d = '0;
               if (!rx_sync_q) begin
                  rx_state_d = RX_DATA;
                  rx_bit_d   = '0;
                  start_ok   = 1'b1;
               end else begin
                  rx_state_d = RX_IDLE;
               end
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               rx_bit_d   = rx_bit_q + 1'b1;
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_IDLE;
`ifdef STOP_BIT_CHK_EN
               if (rx_sync_q) byte_done = 1'b1;
               else           stop_bad  = 1'b1;
`else
               byte_done = 1'b1;
`endif
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // ---------------- Frame assembler ----------------
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]  shd_cmd_q, shd_cmd_d, shd_hi_q, shd_hi_d, shd_lo_q, shd_lo_d;
   logic        frame_done_q, frame_done_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [15:0] data_q, data_d;
   logic        cmd_rdy_q, cmd_rdy_d;
`ifdef STOP_BIT_CHK_EN
   logic        frm_err_q, frm_err_d;
`endif

   always_comb begin
      byte_cnt_d   = byte_cnt_q;
      shd_cmd_d    = shd_cmd_q;
      shd_hi_d     = shd_hi_q;
      shd_lo_d     = shd_lo_q;
      frame_done_d = 1'b0;
      cmd_d        = cmd_q;
      data_d       = data_q;
      cmd_rdy_d    = cmd_rdy_q;
`ifdef STOP_BIT_CHK_EN
      frm_err_d    = 1'b0;
`endif
      if (byte_done) begin
         case (byte_cnt_q)
            2'd0:    begin shd_cmd_d = rx_shift_q; byte_cnt_d = 2'd1; end
            2'd1:    begin shd_hi_d  = rx_shift_q; byte_cnt_d = 2'd2; end
            default: begin
               shd_lo_d     = rx_shift_q;
               byte_cnt_d   = 2'd0;
               frame_done_d = 1'b1;
            end
         endcase
      end
`ifdef STOP_BIT_CHK_EN
      if (stop_bad) begin
         byte_cnt_d = 2'd0;
         shd_cmd_d  = '0;
         shd_hi_d   = '0;
         shd_lo_d   = '0;
         frm_err_d  = 1'b1;
      end
`endif
      // Completion outranks any clear that lands in the same cycle.
      if (frame_done_q) begin
         cmd_d     = shd_cmd_q;
         data_d    = {shd_hi_q, shd_lo_q};
         cmd_rdy_d = 1'b1;
      end else if (clr_cmd_rdy || (start_ok && byte_cnt_q == 2'd0)) begin
         cmd_rdy_d = 1'b0;
      end
   end

   // ---------------- TX engine ----------------
   typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

   tx_state_e     tx_state_q, tx_state_d;
   logic [9:0]    tx_shift_q, tx_shift_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [3:0]    tx_bit_q, tx_bit_d;
   logic          tx_busy_q, tx_busy_d;
   logic          resp_sent_q, resp_sent_d;

   always_comb begin
      tx_state_d  = tx_state_q;
      tx_shift_d  = tx_shift_q;
      tx_cnt_d    = tx_cnt_q;
      tx_bit_d    = tx_bit_q;
      tx_busy_d   = tx_busy_q;
      resp_sent_d = resp_sent_q;
      case (tx_state_q)
         TX_IDLE: begin
            if (snd_resp) begin
               tx_shift_d  = {1'b1, resp, 1'b0};
               tx_cnt_d    = '0;
               tx_bit_d    = '0;
               tx_busy_d   = 1'b1;
               resp_sent_d = 1'b0;
               tx_state_d  = TX_SEND;
            end
         end
         TX_SEND: begin
            tx_cnt_d = tx_cnt_q + 1'b1;
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               // Back-fill with ones so the line rests high once the frame has gone.
               tx_shift_d = {1'b1, tx_shift_q[9:1]};
               if (tx_bit_q == 4'd9) begin
                  tx_state_d  = TX_IDLE;
                  tx_busy_d   = 1'b0;
                  resp_sent_d = 1'b1;
               end else begin
                  tx_bit_d = tx_bit_q + 1'b1;
               end
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   // ---------------- State registers ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         rx_prev_q    <= 1'b1;
         rx_state_q   <= RX_IDLE;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_shift_q   <= '0;
         byte_cnt_q   <= '0;
         shd_cmd_q    <= '0;
         shd_hi_q     <= '0;
         shd_lo_q     <= '0;
         frame_done_q <= 1'b0;
         cmd_q        <= '0;
         data_q       <= '0;
         cmd_rdy_q    <= 1'b0;
`ifdef STOP_BIT_CHK_EN
         frm_err_q    <= 1'b0;
`endif
         tx_state_q   <= TX_IDLE;
         tx_shift_q   <= '1;
         tx_cnt_q     <= '0;
         tx_bit_q     <= '0;
         tx_busy_q    <= 1'b0;
         resp_sent_q  <= 1'b0;
      end else begin
         rx_meta_q    <= RX;
         rx_sync_q    <= rx_meta_q;
         rx_prev_q    <= rx_sync_q;
         rx_state_q   <= rx_state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_shift_q   <= rx_shift_d;
         byte_cnt_q   <= byte_cnt_d;
         shd_cmd_q    <= shd_cmd_d;
         shd_hi_q     <= shd_hi_d;
         shd_lo_q     <= shd_lo_d;
         frame_done_q <= frame_done_d;
         cmd_q        <= cmd_d;
         data_q       <= data_d;
         cmd_rdy_q    <= cmd_rdy_d;
`ifdef STOP_BIT_CHK_EN
         frm_err_q    <= frm_err_d;
`endif
         tx_state_q   <= tx_state_d;
         tx_shift_q   <= tx_shift_d;
         tx_cnt_q     <= tx_cnt_d;
         tx_bit_q     <= tx_bit_d;
         tx_busy_q    <= tx_busy_d;
         resp_sent_q  <= resp_sent_d;
      end
   end

   assign TX        = tx_shift_q[0];
   assign cmd       = cmd_q;
   assign data      = data_q;
   assign cmd_rdy   = cmd_rdy_q;
   assign tx_busy   = tx_busy_q;
   assign resp_sent = resp_sent_q;
`ifdef STOP_BIT_CHK_EN
   assign frm_err   = frm_err_q;
`else
   assign frm_err   = 1'b0;
`endif

endmodule
